// File: rtl/multdiv_if.sv
// Handshake bundle between the main control FSM, the mult/div units and the
// mult/div sequencer.
//   Requests  : mult_req, div_req, divisor_zero (from main control)
//   Unit done : mult_done, div_done (from multUnit/divUnit)
//   Controls  : multOP, divOP (unit start), MultDiv (HI/LO mux), HiLow (HI/LO we)
//   Status    : busy, done, div_zero_exc, timeout_err (to main control)
// Modports: ctrl = the sequencer, env = everything around it.
interface multdiv_if;
  logic mult_req;
  logic div_req;
  logic divisor_zero;
  logic mult_done;
  logic div_done;
  logic multOP;
  logic divOP;
  logic MultDiv;
  logic HiLow;
  logic busy;
  logic done;
  logic div_zero_exc;
  logic timeout_err;

  modport ctrl (
    input  mult_req, div_req, divisor_zero, mult_done, div_done,
    output multOP, divOP, MultDiv, HiLow, busy, done, div_zero_exc, timeout_err
  );

  modport env (
    output mult_req, div_req, divisor_zero, mult_done, div_done,
    input  multOP, divOP, MultDiv, HiLow, busy, done, div_zero_exc, timeout_err
  );
endinterface

// File: rtl/multdiv_ctrl.sv
// Sequencer for the shared multiply/divide resource of the multicycle datapath.
// Takes one-cycle requests in IDLE, pulses the unit start, waits (bounded by
// TIMEOUT cycles) for the unit, then pulses the HI/LO write with the mux held
// stable, and reports done / divide-by-zero / timeout.
// Ports:
//   clk    : system clock, rising edge
//   reset  : synchronous, active-high
//   md_bus : multdiv_if.ctrl handshake bundle (see multdiv_if.sv)
module multdiv_ctrl #(
  parameter  int TIMEOUT = 64,
  localparam int CW      = $clog2(TIMEOUT) + 1
) (
  input  logic         clk,
  input  logic         reset,
  multdiv_if.ctrl      md_bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_M_START,
    S_M_WAIT,
    S_D_START,
    S_D_WAIT,
    S_WRITE,
    S_FIN,
    S_EXC,
    S_ERR
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic            r_multdiv;

  logic            w_cnt_max;
  logic            w_unit_done;

  // Last WAIT cycle: the TIMEOUT-th cycle without a done aborts.
  assign w_cnt_max   = (r_cnt == CW'(TIMEOUT - 1));
  // Only the done of the unit actually being waited on counts.
  assign w_unit_done = ((r_state == S_M_WAIT) && md_bus.mult_done) ||
                       ((r_state == S_D_WAIT) && md_bus.div_done);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        // Multiply wins a tie; the losing divide is dropped.
        if (md_bus.mult_req)                               w_next = S_M_START;
        else if (md_bus.div_req && md_bus.divisor_zero)    w_next = S_EXC;
        else if (md_bus.div_req)                           w_next = S_D_START;
      end
      S_M_START: w_next = S_M_WAIT;
      S_D_START: w_next = S_D_WAIT;
      S_M_WAIT, S_D_WAIT: begin
        if (w_unit_done)    w_next = S_WRITE;
        else if (w_cnt_max) w_next = S_ERR;
      end
      S_WRITE:   w_next = S_FIN;
      S_FIN:     w_next = S_IDLE;
      S_EXC:     w_next = S_IDLE;
      S_ERR:     w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Wait counter: cleared on start, counts WAIT cycles, saturates at the
  // abort point so it can never wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else begin
      case (r_state)
        S_M_START, S_D_START: r_cnt <= '0;
        S_M_WAIT, S_D_WAIT: begin
          if (!w_unit_done && !w_cnt_max) r_cnt <= r_cnt + CW'(1);
        end
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // HI/LO source select is only touched on a unit start, so it holds through
  // WRITE and in IDLE.
  always_ff @(posedge clk) begin
    if (reset)                       r_multdiv <= 1'b0;
    else if (r_state == S_M_START)   r_multdiv <= 1'b0;
    else if (r_state == S_D_START)   r_multdiv <= 1'b1;
  end

  // Moore outputs, decoded from the state register only.
  assign md_bus.multOP       = (r_state == S_M_START);
  assign md_bus.divOP        = (r_state == S_D_START);
  assign md_bus.HiLow        = (r_state == S_WRITE);
  assign md_bus.done         = (r_state == S_FIN);
  assign md_bus.div_zero_exc = (r_state == S_EXC);
  assign md_bus.timeout_err  = (r_state == S_ERR);
  assign md_bus.busy         = (r_state != S_IDLE);
  assign md_bus.MultDiv      = r_multdiv;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl (TIMEOUT=8): per-cycle output checks plus a
// scoreboard of expected outcomes (HiLow / exception / timeout, with MultDiv).
module tb_multdiv_ctrl;
  localparam int TO = 8;

  // output vector {multOP,divOP,MultDiv,HiLow,busy,done,div_zero_exc,timeout_err}
  localparam logic [7:0] MOP = 8'h80, DOP = 8'h40, MD = 8'h20, HL = 8'h10,
                         BSY = 8'h08, DN = 8'h04, DZX = 8'h02, TOE = 8'h01;
  localparam logic [7:0] ALL = 8'hFF, NMD = 8'hDF;
  // input vector {mult_req,div_req,divisor_zero,mult_done,div_done}
  localparam logic [4:0] NONE = 5'b00000, MREQ = 5'b10000, DREQ = 5'b01000,
                         DZ = 5'b00100, MDON = 5'b00010, DDON = 5'b00001;

  logic clk;
  logic reset;
  multdiv_if bif();

  multdiv_ctrl #(.TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .md_bus(bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  logic [3:0] sbq[$];   // {HiLow,div_zero_exc,timeout_err,MultDiv}

  function automatic logic [7:0] outs();
    return {bif.multOP, bif.divOP, bif.MultDiv, bif.HiLow,
            bif.busy, bif.done, bif.div_zero_exc, bif.timeout_err};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, step past the edge, check the outputs and any
  // terminal event against the scoreboard.
  task automatic t(input logic rst, input logic [4:0] in, input logic [7:0] exp,
                   input logic [7:0] care, input string tag);
    logic [7:0] o;
    logic [3:0] ent;
    reset = rst;
    {bif.mult_req, bif.div_req, bif.divisor_zero, bif.mult_done, bif.div_done} = in;
    @(posedge clk);
    #1;
    reset = 1'b0;
    {bif.mult_req, bif.div_req, bif.divisor_zero, bif.mult_done, bif.div_done} = NONE;
    if (rst) sbq.delete();
    o = outs();
    chk(tag, o & care, exp & care);
    if (bif.HiLow || bif.div_zero_exc || bif.timeout_err) begin
      ent = (sbq.size() != 0) ? sbq.pop_front() : 4'h0;
      chk({tag, "_sb"}, {4'h0, bif.HiLow, bif.div_zero_exc, bif.timeout_err, bif.MultDiv},
          {4'h0, ent});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    {bif.mult_req, bif.div_req, bif.divisor_zero, bif.mult_done, bif.div_done} = NONE;

    // Reset, then idle
    t(1, NONE, 8'h00, ALL, "rst0");
    t(1, NONE, 8'h00, ALL, "rst1");
    for (int i = 0; i < 10; i++) t(0, NONE, 8'h00, ALL, "idle");

    // Multiply, done after 3 WAIT cycles; request during FIN ignored
    sbq.push_back(4'b1000);
    t(0, MREQ, MOP | BSY, ALL, "m_start");
    t(0, NONE, BSY, ALL, "m_wait0");
    t(0, NONE, BSY, ALL, "m_wait1");
    t(0, NONE, BSY, ALL, "m_wait2");
    t(0, MDON, HL | BSY, ALL, "m_write");
    t(0, NONE, DN | BSY, ALL, "m_fin");
    t(0, MREQ, 8'h00, ALL, "m_idle");
    t(0, NONE, 8'h00, ALL, "fin_req_ignored");

    // Divide by zero
    sbq.push_back(4'b0100);
    t(0, DREQ | DZ, DZX | BSY, ALL, "dz_exc");
    t(0, NONE, 8'h00, ALL, "dz_idle");
    t(0, DDON | MDON, 8'h00, ALL, "stray_done_idle");

    // Divide timeout: 8 WAIT cycles, then ERR
    sbq.push_back(4'b0011);
    t(0, DREQ, DOP | BSY, NMD, "d_start");
    for (int i = 0; i < TO; i++) t(0, NONE, MD | BSY, ALL, "d_wait");
    t(0, NONE, TOE | MD | BSY, ALL, "d_timeout");
    t(0, NONE, MD, ALL, "d_to_idle");
    t(0, NONE, MD, ALL, "md_hold");

    // Arbitration and ignored inputs
    sbq.push_back(4'b1000);
    t(0, MREQ | DREQ, MOP | BSY, NMD, "arb_mult");
    t(0, DREQ, BSY, ALL, "arb_wait0");
    t(0, DDON, BSY, ALL, "arb_divreq_ign");
    t(0, DDON | DREQ, BSY, ALL, "arb_divdone_ign");
    t(0, MDON, HL | BSY, ALL, "arb_write");
    t(0, DREQ, DN | BSY, ALL, "arb_fin");
    t(0, NONE, 8'h00, ALL, "arb_idle");

    // Reset mid-wait aborts without HiLow/done
    sbq.push_back(4'b1000);
    t(0, MREQ, MOP | BSY, ALL, "r_start");
    t(0, NONE, BSY, ALL, "r_wait0");
    t(1, NONE, 8'h00, ALL, "r_reset");
    t(0, MDON, 8'h00, ALL, "r_late_done");
    t(0, NONE, 8'h00, ALL, "r_idle");

    // Divide completing normally after the abort
    sbq.push_back(4'b1001);
    t(0, DREQ, DOP | BSY, NMD, "d2_start");
    t(0, NONE, MD | BSY, ALL, "d2_wait0");
    t(0, DDON, HL | MD | BSY, ALL, "d2_write");
    t(0, NONE, DN | MD | BSY, ALL, "d2_fin");
    t(0, NONE, MD, ALL, "d2_idle");

    chk("sb_drained", 8'(sbq.size()), 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
